// File: rtl/stream_pkg.sv
// Shared definitions for the packet arbiter: FSM state encoding and statistics counter width.
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/stream_pkt_arbiter_mux.sv
// Two-way ready/valid stream mux; sel picks the source, en gates both valid and ready.
module stream_pkt_arbiter_mux #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic          en,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready
);

  assign m_data   = sel ? s1_data : s0_data;
  assign m_last   = sel ? s1_last : s0_last;
  assign m_valid  = en & (sel ? s1_valid : s0_valid);
  assign s0_ready = en & ~sel & m_ready;
  assign s1_ready = en &  sel & m_ready;

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-aware two-input round-robin arbiter with one registered output stage.
// Optional per-input packet counters are enabled by defining STREAM_PKT_ARBITER_STATS_EN.
module stream_pkt_arbiter
  import stream_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DW-1:0]      s0_data_i,
  input  logic               s0_valid_i,
  input  logic               s0_last_i,
  output logic               s0_ready_o,
  input  logic [DW-1:0]      s1_data_i,
  input  logic               s1_valid_i,
  input  logic               s1_last_i,
  output logic               s1_ready_o,
  output logic [DW-1:0]      m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
`ifdef STREAM_PKT_ARBITER_STATS_EN
  output logic [STATS_W-1:0] pkt_cnt0_o,
  output logic [STATS_W-1:0] pkt_cnt1_o,
`endif
  output logic [1:0]         grant_o
);

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic [1:0]      grant_q, grant_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;

  logic            stage_ready;
  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            accept;
  logic            last_acc;

  assign stage_ready = ~m_valid_q | m_ready_i;
  assign accept      = sel_valid & stage_ready;
  assign last_acc    = accept & sel_last;

  stream_pkt_arbiter_mux #(.DW(DW)) u_mux (
    .sel      (grant_q[1]),
    .en       (state_q != IDLE),
    .s0_data  (s0_data_i),
    .s0_valid (s0_valid_i),
    .s0_last  (s0_last_i),
    .s0_ready (s0_ready_o),
    .s1_data  (s1_data_i),
    .s1_valid (s1_valid_i),
    .s1_last  (s1_last_i),
    .s1_ready (s1_ready_o),
    .m_data   (sel_data),
    .m_valid  (sel_valid),
    .m_last   (sel_last),
    .m_ready  (stage_ready)
  );

  // Grant only moves on an accepted last beat, preferring the other input.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    if (stage_ready) begin
      m_valid_d = accept;
      if (accept) begin
        m_data_d = sel_data;
        m_last_d = sel_last;
      end
    end

    case (state_q)
      IDLE: begin
        if (s0_valid_i && s1_valid_i) state_d = prio_q ? LOCK1 : LOCK0;
        else if (s0_valid_i)          state_d = LOCK0;
        else if (s1_valid_i)          state_d = LOCK1;
      end
      LOCK0: begin
        if (last_acc) begin
          prio_d = 1'b1;
          if (s1_valid_i)      state_d = LOCK1;
          else if (s0_valid_i) state_d = LOCK0;
          else                 state_d = IDLE;
        end
      end
      LOCK1: begin
        if (last_acc) begin
          prio_d = 1'b0;
          if (s0_valid_i)      state_d = LOCK0;
          else if (s1_valid_i) state_d = LOCK1;
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = {state_d == LOCK1, state_d == LOCK0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 2'b00;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign grant_o   = grant_q;
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;

`ifdef STREAM_PKT_ARBITER_STATS_EN
  logic [STATS_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [STATS_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (last_acc && state_q == LOCK0) pkt_cnt0_d = pkt_cnt0_q + STATS_W'(1);
    if (last_acc && state_q == LOCK1) pkt_cnt1_d = pkt_cnt1_q + STATS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0_o = pkt_cnt0_q;
  assign pkt_cnt1_o = pkt_cnt1_q;
`endif

endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
- Two-input, packet-aware round-robin arbiter for ready/valid streams with an end-of-packet marker.
- Drives the select of a two-way stream mux and holds the grant until the granted packet's last beat is accepted.
- Adds one registered output stage.
- Merges two packet sources (e.g. frame header generator and pixel pipeline) onto one downstream stream without interleaving beats of different packets.

Parameters:
- DW, 8, data width in bits; must be at least 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active low.
- s0_data_i  input  DW  input 0 data.
- s0_valid_i  input  1  input 0 valid.
- s0_last_i  input  1  input 0 last beat of packet.
- s0_ready_o  output  1  input 0 ready.
- s1_data_i  input  DW  input 1 data.
- s1_valid_i  input  1  input 1 valid.
- s1_last_i  input  1  input 1 last beat of packet.
- s1_ready_o  output  1  input 1 ready.
- m_data_o  output  DW  output data (registered).
- m_valid_o  output  1  output valid (registered).
- m_last_o  output  1  output last (registered).
- m_ready_i  input  1  output ready.
- grant_o  output  2  one-hot current grant; 00 when idle.

Behaviour:
- One clock domain. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: state IDLE, grant_o 00, m_valid_o 0, m_last_o 0, m_data_o 0, prio pointer = 0 (input 0 wins the first tie).
- stage_ready = !m_valid_o | m_ready_i.
- sX_ready_o = grant_o[X] & stage_ready. Both readies are 0 in IDLE.
- Beat accepted on input X when sXvalid & sXready. On acceptance, m_data/m_valid/m_last load sX data/1/last on the next edge.
- If stage_ready and no beat is accepted, m_valid_o clears to 0 on the next edge.
- Latency: 1 cycle input to output. Full throughput (one beat per cycle) sustained within a packet.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: if exactly one valid, go to LOCK of that input. If both valid, go to LOCK of the input indicated by prio. If none valid, stay in IDLE. Arbitration takes one cycle, so no beat passes in IDLE.
  - LOCKX: hold grant regardless of the other input's valid.
  - On an accepted beat with last=1, re-arbitrate in the same edge:
    - other input valid -> LOCK of the other input;
    - else own input valid -> stay in LOCKX;
    - else -> IDLE.
  - Back-to-back packets therefore have no bubble.
- prio pointer: set to the non-granted input whenever a last beat is accepted (round robin).
- Grant change only happens on an accepted last beat. A valid drop mid-packet keeps the lock indefinitely.
- A single-beat packet (valid with last=1 on the first beat) releases after that one beat.
- Output stall (m_ready_i=0 with m_valid_o=1): stage_ready=0, so no input is ready and the output register holds. Data must not change while m_valid_o=1 && !m_ready_i.
- Reset mid-packet: everything returns to reset values on that edge. Any partial packet in flight is dropped and is the sources' responsibility.
- grant_o is registered: it equals the one-hot of the LOCK state and is 00 in IDLE.

Optional Feature:
- Macro STREAM_PKT_ARBITER_STATS_EN.
- When defined, adds outputs pkt_cnt0_o and pkt_cnt1_o, each 16 bits.
  - Each counts accepted last beats on its input.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0.
- When undefined, these ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package stream_pkg holds:
  - FSM state encoding: IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2;
  - localparam STATS_W=16.
- The data path selection uses the existing two-way stream mux as the one sub-module: sel = grant_o[1], with valid/ready gated by the FSM.
- The output register and FSM are local to this block.

Test Plan:
- Reset with rst_n=0 for 3 cycles, s0/s1 valid high -> grant_o=00, m_valid_o=0, both readies 0 throughout reset.
- Only s0 sends a 4-beat packet (data 0x10..0x13, last on 0x13), m_ready_i=1 -> grant_o=01 after 1 cycle; m_data_o shows 0x10..0x13 on consecutive cycles; back to IDLE after last.
- Both valid continuously with 3-beat packets each -> grants alternate 01,10,01,10 starting with input 0; no beats of different packets interleave; no idle cycle between packets.
- s0 packet mid-flight, s1 asserts valid -> s1_ready_o stays 0 until s0 last is accepted; s1 is granted the next cycle.
- m_ready_i held 0 for 5 cycles mid-packet -> m_data_o/m_last_o stable, no input ready. Release -> remaining beats pass in order with none lost or duplicated.
- With STREAM_PKT_ARBITER_STATS_EN: 3 packets on s0 and 2 on s1 -> pkt_cnt0_o=3, pkt_cnt1_o=2. Preload via 65536 s0 single-beat packets -> pkt_cnt0_o wraps to 0.
